ld_st_rs: RTL and testbench
===========================

Name: ld_st_rs

Overview:
- In-order load/store reservation station that consumes the IQtoRS_ld_st issue bundle from the instruction queue.
- Buffers up to DEPTH memory ops and snoops the common data bus (CDB) to fill pending operands by ROB tag.
- Presents the oldest op to the memory unit once its operands are ready: effective address for loads, address plus store data for stores.
- Sits between the issue queue/register file and the data-cache access unit; strict program order, no load/store reordering.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- ROB_W, 5, ROB tag width; must match the dest_rob/src_rob fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_RS  in  1  enqueue strobe from IQ.
- dest_rob  in  ROB_W  ROB index of the op.
- src1_val  in  32  base register value.
- src1_valid  in  1  src1_val is valid.
- src1_rob  in  ROB_W  producer tag for src1 when not valid.
- src2_val  in  32  store data value; ignored for loads.
- src2_valid  in  1  src2_val is valid.
- src2_rob  in  ROB_W  producer tag for src2.
- is_st  in  1  1 = store, 0 = load.
- funct3  in  3  width/sign code: lb/lh/lw/lbu/lhu, or sb/sh/sw.
- imm  in  32  sign-extended offset.
- rs_full  out  1  no free entry.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rob  in  ROB_W  broadcast tag.
- cdb_val  in  32  broadcast value.
- flush  in  1  synchronous squash of all entries.
- mem_req_valid  out  1  head op is ready.
- mem_req_ready  in  1  memory unit accepts the head op.
- mem_addr  out  32  src1 + imm of the head entry.
- mem_wdata  out  32  head src2 value (stores).
- mem_is_st  out  1  head is_st.
- mem_funct3  out  3  head funct3.
- mem_dest_rob  out  ROB_W  head dest_rob.
- count  out  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, rst=1):
  - head ptr = tail ptr = count = 0; all entry valid bits and storage cleared.
  - rs_full=0, mem_req_valid=0; mem_addr, mem_wdata, mem_funct3, mem_dest_rob, mem_is_st all 0.
  - Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer indexed by head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
- Full/empty:
  - rs_full = (count == DEPTH); empty = (count == 0). Both are registered-state derived, with no same-cycle combinational path from inputs.
- Enqueue:
  - On a clk edge with load_RS=1 and rs_full=0, write the entry at tail, tail += 1.
  - load_RS while rs_full=1 is ignored: no state change, no error flag.
  - Enqueue while full is not permitted even if a dequeue occurs in the same cycle.
- CDB snoop:
  - Each cycle with cdb_valid=1, every valid entry whose srcN_valid=0 and srcN_rob==cdb_rob captures cdb_val and sets srcN_valid=1.
  - Applies independently to src1 and src2.
- Same-cycle enqueue and CDB match:
  - An incoming op with src1_valid=0 and src1_rob==cdb_rob is written already valid with cdb_val.
  - The same rule applies to src2.
- Ready:
  - Head is ready when the entry is valid and src1_valid=1, and additionally src2_valid=1 if is_st.
  - mem_req_valid = head ready, driven combinationally from registered entry state.
  - Earliest issue is the cycle after enqueue.
- Issue data:
  - mem_addr = head.src1_val + head.imm, modulo 2^32 (wraps, no overflow flag).
  - mem_wdata = head.src2_val.
- Dequeue:
  - On a clk edge with mem_req_valid=1 and mem_req_ready=1: clear the head entry, head += 1.
  - Once mem_req_valid rises it stays high with stable payload until accepted or flushed.
- Counter: count updates +1 on enqueue, -1 on dequeue, and is unchanged on both together.
- Ordering: only the head may issue. A younger ready op waits behind a non-ready head.
- Flush:
  - flush=1 at a clk edge empties the buffer: pointers reset, count=0, all valids cleared.
  - Flush has priority over any simultaneous enqueue, dequeue, or CDB update.
  - mem_req_valid=0 from the following cycle.
- CDB and dequeue on the same head in the same cycle: the dequeue completes and the snoop result for that entry is discarded.

Test Plan:
- Reset then enqueue load (dest_rob=3, src1 valid=0x1000, imm=0x10, funct3=lw) -> next cycle mem_req_valid=1, mem_addr=0x1010, mem_dest_rob=3; accept with ready=1 -> count returns to 0.
- Enqueue store (src1 valid=0x200, src2 invalid tag 7, imm=-4) -> mem_req_valid stays 0; CDB tag 7 value 0xDEADBEEF -> next cycle mem_req_valid=1, mem_addr=0x1FC, mem_wdata=0xDEADBEEF, mem_is_st=1.
- Fill 8 entries with ready operands, mem_req_ready=0 -> rs_full=1, count=8; ninth load_RS is ignored; one accept -> rs_full=0; 20 more enqueue/dequeue ops confirm pointer wrap and order.
- Head waits on tag 5 while entry 2 is ready -> no issue until CDB tag 5 arrives, then entries issue in order (1, 2).
- Enqueue with src1_rob=9 invalid in the same cycle as CDB tag 9 value 0x40, imm=0 -> issues next cycle with mem_addr=0x40.
- With 3 entries, assert flush together with load_RS and a CDB broadcast -> count=0, mem_req_valid=0 next cycle; async rst pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/ld_st_rs.sv
// In-order load/store reservation station: buffers issued memory ops, fills
// pending operands from the CDB, and presents only the oldest op to memory.
module ld_st_rs #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_RS,
  input  logic [ROB_W-1:0]         dest_rob,
  input  logic [31:0]              src1_val,
  input  logic                     src1_valid,
  input  logic [ROB_W-1:0]         src1_rob,
  input  logic [31:0]              src2_val,
  input  logic                     src2_valid,
  input  logic [ROB_W-1:0]         src2_rob,
  input  logic                     is_st,
  input  logic [2:0]               funct3,
  input  logic [31:0]              imm,
  output logic                     rs_full,
  input  logic                     cdb_valid,
  input  logic [ROB_W-1:0]         cdb_rob,
  input  logic [31:0]              cdb_val,
  input  logic                     flush,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_is_st,
  output logic [2:0]               mem_funct3,
  output logic [ROB_W-1:0]         mem_dest_rob,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid, s1_v, s2_v, st_q;
  logic [31:0]      s1_val [DEPTH];
  logic [31:0]      s2_val [DEPTH];
  logic [31:0]      imm_q  [DEPTH];
  logic [ROB_W-1:0] s1_rob [DEPTH];
  logic [ROB_W-1:0] s2_rob [DEPTH];
  logic [ROB_W-1:0] dest_q [DEPTH];
  logic [2:0]       f3_q   [DEPTH];
  logic [PW-1:0]    head, tail;
  logic             enq, deq, s1_fwd, s2_fwd;

  assign rs_full       = (count == CW'(DEPTH));
  assign enq           = load_RS && !rs_full;
  assign mem_req_valid = valid[head] && s1_v[head] && (!st_q[head] || s2_v[head]);
  assign deq           = mem_req_valid && mem_req_ready;

  // An op arriving while its producer is on the CDB is captured already resolved.
  assign s1_fwd = cdb_valid && !src1_valid && (src1_rob == cdb_rob);
  assign s2_fwd = cdb_valid && !src2_valid && (src2_rob == cdb_rob);

  assign mem_addr     = s1_val[head] + imm_q[head];
  assign mem_wdata    = s2_val[head];
  assign mem_is_st    = st_q[head];
  assign mem_funct3   = f3_q[head];
  assign mem_dest_rob = dest_q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      s1_v  <= '0;
      s2_v  <= '0;
      st_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1_val[i] <= '0;
        s2_val[i] <= '0;
        imm_q[i]  <= '0;
        s1_rob[i] <= '0;
        s2_rob[i] <= '0;
        dest_q[i] <= '0;
        f3_q[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      s1_v  <= '0;
      s2_v  <= '0;
      st_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1_val[i] <= '0;
        s2_val[i] <= '0;
        imm_q[i]  <= '0;
        s1_rob[i] <= '0;
        s2_rob[i] <= '0;
        dest_q[i] <= '0;
        f3_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && valid[i] && !s1_v[i] && (s1_rob[i] == cdb_rob)) begin
          s1_v[i]   <= 1'b1;
          s1_val[i] <= cdb_val;
        end
        if (cdb_valid && valid[i] && !s2_v[i] && (s2_rob[i] == cdb_rob)) begin
          s2_v[i]   <= 1'b1;
          s2_val[i] <= cdb_val;
        end
      end
      if (enq) begin
        valid[tail]  <= 1'b1;
        s1_v[tail]   <= src1_valid || s1_fwd;
        s1_val[tail] <= s1_fwd ? cdb_val : src1_val;
        s1_rob[tail] <= src1_rob;
        s2_v[tail]   <= src2_valid || s2_fwd;
        s2_val[tail] <= s2_fwd ? cdb_val : src2_val;
        s2_rob[tail] <= src2_rob;
        st_q[tail]   <= is_st;
        f3_q[tail]   <= funct3;
        imm_q[tail]  <= imm;
        dest_q[tail] <= dest_rob;
        tail         <= tail + 1'b1;
      end
      // Clearing the departing head last drops any snoop result aimed at it.
      if (deq) begin
        valid[head]  <= 1'b0;
        s1_v[head]   <= 1'b0;
        s2_v[head]   <= 1'b0;
        st_q[head]   <= 1'b0;
        s1_val[head] <= '0;
        s2_val[head] <= '0;
        imm_q[head]  <= '0;
        s1_rob[head] <= '0;
        s2_rob[head] <= '0;
        dest_q[head] <= '0;
        f3_q[head]   <= '0;
        head         <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ld_st_rs.sv
// Scoreboard bench for ld_st_rs: a queue-based model of in-order ops is
// compared against the DUT's issue interface every cycle.
module tb_ld_st_rs;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_RS = 1'b0;
  logic [ROB_W-1:0] dest_rob = '0;
  logic [31:0]      src1_val = '0;
  logic             src1_valid = 1'b0;
  logic [ROB_W-1:0] src1_rob = '0;
  logic [31:0]      src2_val = '0;
  logic             src2_valid = 1'b0;
  logic [ROB_W-1:0] src2_rob = '0;
  logic             is_st = 1'b0;
  logic [2:0]       funct3 = '0;
  logic [31:0]      imm = '0;
  logic             rs_full;
  logic             cdb_valid = 1'b0;
  logic [ROB_W-1:0] cdb_rob = '0;
  logic [31:0]      cdb_val = '0;
  logic             flush = 1'b0;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_is_st;
  logic [2:0]       mem_funct3;
  logic [ROB_W-1:0] mem_dest_rob;
  logic [CW-1:0]    count;

  ld_st_rs #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .load_RS(load_RS), .dest_rob(dest_rob),
    .src1_val(src1_val), .src1_valid(src1_valid), .src1_rob(src1_rob),
    .src2_val(src2_val), .src2_valid(src2_valid), .src2_rob(src2_rob),
    .is_st(is_st), .funct3(funct3), .imm(imm), .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_is_st(mem_is_st),
    .mem_funct3(mem_funct3), .mem_dest_rob(mem_dest_rob), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_W-1:0] dest;
    logic [31:0]      s1;
    logic             s1v;
    logic [ROB_W-1:0] s1r;
    logic [31:0]      s2;
    logic             s2v;
    logic [ROB_W-1:0] s2r;
    logic             st;
    logic [2:0]       f3;
    logic [31:0]      imm;
  } op_t;

  op_t mq[$];
  int  tests = 0;
  int  fails = 0;
  op_t nop_op;

  function automatic op_t mk_op(logic [ROB_W-1:0] dest, logic [31:0] s1, logic s1v,
                                logic [ROB_W-1:0] s1r, logic [31:0] s2, logic s2v,
                                logic [ROB_W-1:0] s2r, logic st, logic [2:0] f3,
                                logic [31:0] im);
    op_t o;
    o.dest = dest; o.s1 = s1; o.s1v = s1v; o.s1r = s1r;
    o.s2 = s2; o.s2v = s2v; o.s2r = s2r; o.st = st; o.f3 = f3; o.imm = im;
    return o;
  endfunction

  function automatic bit op_ready(op_t o);
    return o.s1v && (!o.st || o.s2v);
  endfunction

  // Reference model: the buffer is just an ordered list of ops.
  always @(posedge clk) begin
    int  n;
    op_t o;
    if (!rst) begin
      if (flush) begin
        mq.delete();
      end else begin
        n = mq.size();
        if (n > 0 && op_ready(mq[0]) && mem_req_ready) void'(mq.pop_front());
        if (cdb_valid) begin
          foreach (mq[i]) begin
            if (!mq[i].s1v && mq[i].s1r == cdb_rob) begin mq[i].s1v = 1'b1; mq[i].s1 = cdb_val; end
            if (!mq[i].s2v && mq[i].s2r == cdb_rob) begin mq[i].s2v = 1'b1; mq[i].s2 = cdb_val; end
          end
        end
        if (load_RS && n < DEPTH) begin
          o = mk_op(dest_rob, src1_val, src1_valid, src1_rob, src2_val, src2_valid,
                    src2_rob, is_st, funct3, imm);
          if (cdb_valid && !o.s1v && o.s1r == cdb_rob) begin o.s1v = 1'b1; o.s1 = cdb_val; end
          if (cdb_valid && !o.s2v && o.s2r == cdb_rob) begin o.s2v = 1'b1; o.s2 = cdb_val; end
          mq.push_back(o);
        end
      end
    end
  end

  // Monitor: checks issue handshake, payload and occupancy against the model.
  always @(negedge clk) begin
    bit  exp_rdy;
    op_t h;
    if (!rst) begin
      exp_rdy = (mq.size() > 0) && op_ready(mq[0]);
      tests++;
      if (mem_req_valid !== exp_rdy) begin
        fails++;
        $display("[TB] FAIL mem_req_valid at %0t: got %0b expected %0b", $time, mem_req_valid, exp_rdy);
      end
      tests++;
      if (count !== CW'(mq.size()) || rs_full !== (mq.size() == DEPTH)) begin
        fails++;
        $display("[TB] FAIL occupancy at %0t: got count=%0d full=%0b expected count=%0d full=%0b",
                 $time, count, rs_full, mq.size(), mq.size() == DEPTH);
      end
      if (exp_rdy && mem_req_valid) begin
        h = mq[0];
        tests++;
        if (mem_addr !== h.s1 + h.imm || mem_is_st !== h.st || mem_funct3 !== h.f3 ||
            mem_dest_rob !== h.dest || (h.st && mem_wdata !== h.s2)) begin
          fails++;
          $display("[TB] FAIL payload at %0t: got addr=%h wdata=%h st=%0b f3=%0d rob=%0d expected addr=%h wdata=%h st=%0b f3=%0d rob=%0d",
                   $time, mem_addr, mem_wdata, mem_is_st, mem_funct3, mem_dest_rob,
                   h.s1 + h.imm, h.s2, h.st, h.f3, h.dest);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge and advances past the next one.
  task automatic apply_stimulus(input bit ld, input op_t o, input bit cv,
                                input logic [ROB_W-1:0] cr, input logic [31:0] cd,
                                input bit rdy, input bit fl);
    load_RS = ld; dest_rob = o.dest; src1_val = o.s1; src1_valid = o.s1v; src1_rob = o.s1r;
    src2_val = o.s2; src2_valid = o.s2v; src2_rob = o.s2r; is_st = o.st; funct3 = o.f3;
    imm = o.imm; cdb_valid = cv; cdb_rob = cr; cdb_val = cd; mem_req_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
    load_RS = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, nop_op, 1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_RS = 1'b0; cdb_valid = 1'b0; flush = 1'b0; mem_req_ready = 1'b0;
    #1;
    mq.delete();
    check_output("rst_valid", 32'(mem_req_valid), 32'd0);
    check_output("rst_full", 32'(rs_full), 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_addr", mem_addr, 32'd0);
    check_output("rst_wdata", mem_wdata, 32'd0);
    check_output("rst_misc", {mem_is_st, mem_funct3, 32'(mem_dest_rob)}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic op_t rand_op();
    return mk_op(ROB_W'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 1) == 1),
                 ROB_W'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 1) == 1),
                 ROB_W'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                 3'($urandom_range(0, 7)), $urandom);
  endfunction

  initial begin
    nop_op = mk_op('0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    do_reset();

    // Simple ready load.
    apply_stimulus(1'b1, mk_op(5'd3, 32'h1000, 1'b1, '0, '0, 1'b0, '0, 1'b0, 3'd2, 32'h10),
                   1'b0, '0, '0, 1'b0, 1'b0);
    check_output("ld_valid", 32'(mem_req_valid), 32'd1);
    check_output("ld_addr", mem_addr, 32'h1010);
    check_output("ld_rob", 32'(mem_dest_rob), 32'd3);
    idle(1'b1, 1);
    check_output("ld_drained", 32'(count), 32'd0);

    // Store waiting on its data operand.
    apply_stimulus(1'b1, mk_op(5'd4, 32'h200, 1'b1, '0, '0, 1'b0, 5'd7, 1'b1, 3'd2, 32'hFFFF_FFFC),
                   1'b0, '0, '0, 1'b0, 1'b0);
    check_output("st_wait", 32'(mem_req_valid), 32'd0);
    apply_stimulus(1'b0, nop_op, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0);
    check_output("st_valid", 32'(mem_req_valid), 32'd1);
    check_output("st_addr", mem_addr, 32'h1FC);
    check_output("st_wdata", mem_wdata, 32'hDEADBEEF);
    check_output("st_is_st", 32'(mem_is_st), 32'd1);
    idle(1'b1, 1);

    // Fill, overflow attempt, then streaming through the wrap point.
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(1'b1, mk_op(ROB_W'(i), $urandom, 1'b1, '0, '0, 1'b0, '0, 1'b0, 3'd2, 32'(i)),
                     1'b0, '0, '0, 1'b0, 1'b0);
    check_output("full_flag", 32'(rs_full), 32'd1);
    check_output("full_count", 32'(count), 32'd8);
    apply_stimulus(1'b1, mk_op(5'd30, 32'h5, 1'b1, '0, '0, 1'b0, '0, 1'b0, 3'd0, 32'h0),
                   1'b0, '0, '0, 1'b0, 1'b0);
    check_output("ovf_count", 32'(count), 32'd8);
    idle(1'b1, 1);
    check_output("after_accept_full", 32'(rs_full), 32'd0);
    for (int i = 0; i < 20; i++)
      apply_stimulus(1'b1, mk_op(ROB_W'(i + 8), $urandom, 1'b1, '0, '0, 1'b0, '0, 1'b0, 3'd4, $urandom),
                     1'b0, '0, '0, 1'b1, 1'b0);
    check_output("stream_count", 32'(count), 32'd7);
    idle(1'b1, DEPTH);

    // Non-ready head blocks a younger ready op.
    apply_stimulus(1'b1, mk_op(5'd1, '0, 1'b0, 5'd5, '0, 1'b0, '0, 1'b0, 3'd2, 32'h8),
                   1'b0, '0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b1, mk_op(5'd2, 32'h400, 1'b1, '0, '0, 1'b0, '0, 1'b0, 3'd2, 32'h4),
                   1'b0, '0, '0, 1'b0, 1'b0);
    idle(1'b1, 3);
    check_output("blocked_count", 32'(count), 32'd2);
    apply_stimulus(1'b0, nop_op, 1'b1, 5'd5, 32'h300, 1'b1, 1'b0);
    check_output("unblocked_rob", 32'(mem_dest_rob), 32'd1);
    idle(1'b1, 3);
    check_output("unblocked_count", 32'(count), 32'd0);

    // Operand forwarded from the CDB in the enqueue cycle.
    apply_stimulus(1'b1, mk_op(5'd6, '0, 1'b0, 5'd9, '0, 1'b0, '0, 1'b0, 3'd2, 32'h0),
                   1'b1, 5'd9, 32'h40, 1'b0, 1'b0);
    check_output("fwd_valid", 32'(mem_req_valid), 32'd1);
    check_output("fwd_addr", mem_addr, 32'h40);
    idle(1'b1, 1);

    // Flush beats a simultaneous enqueue and broadcast.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, mk_op(ROB_W'(i), '0, 1'b0, 5'd3, '0, 1'b0, '0, 1'b0, 3'd2, 32'h0),
                     1'b0, '0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b1, mk_op(5'd9, 32'h1, 1'b1, '0, '0, 1'b0, '0, 1'b0, 3'd2, 32'h0),
                   1'b1, 5'd3, 32'h77, 1'b1, 1'b1);
    check_output("flush_count", 32'(count), 32'd0);
    check_output("flush_valid", 32'(mem_req_valid), 32'd0);

    // Randomised traffic with occasional flushes.
    for (int c = 0; c < 400; c++)
      apply_stimulus(($urandom_range(0, 2) != 0), rand_op(), ($urandom_range(0, 1) == 1),
                     ROB_W'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 49) == 0));

    // Asynchronous reset while the buffer is occupied.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, rand_op(), 1'b0, '0, '0, 1'b0, 1'b0);
    do_reset();
    idle(1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
